sc_chain_loader: RTL and testbench
==================================

# sc_chain_loader

Parametrised slow-control serializer for daisy-chained front-end ASICs. It captures a full configuration image on a start strobe and shifts it out on `D_SC` with a generated serial clock `SCK_SC` and chain enable. An optional second verify pass reshifts the image while comparing the chain's returned stream `Q_SC` bit-by-bit. It sits between the register-file configuration image and the board-level slow-control lines, replacing the fixed-length, reset-loaded serializer.

## Interface
Parameters:
- `SC_BITS`, 829, configuration bits per ASIC.
- `N_ASIC`, 1, number of ASICs in the daisy chain; `TOTAL = SC_BITS*N_ASIC`.
- `CLK_DIV`, 1, half-period of `SCK_SC` in `CK_SC` cycles (≥1).
- `LSB_FIRST`, 1, 1: `cfg_data[0]` shifted first; 0: `cfg_data[TOTAL-1]` first.

Ports:
- `CK_SC` in 1: the only clock. All logic runs on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a transfer. Sampled only in IDLE.
- `verify_en` in 1: sampled with `start`. Adds the verify pass.
- `cfg_data` in TOTAL: image. Slot i = `cfg_data[SC_BITS*i +: SC_BITS]`. With `LSB_FIRST=1`, slot 0 lands in the ASIC farthest from the FPGA.
- `Q_SC` in 1: serial return from the chain end.
- `D_SC` out 1: serial data.
- `SCK_SC` out 1: serial clock.
- `SC_EN` out 1: high while shifting.
- `busy` out 1: high from accepted start until DONE.
- `done` out 1: one-cycle pulse at completion.
- `err_cnt` out $clog2(TOTAL+1): verify mismatches.
- `verify_ok` out 1: `err_cnt==0` for the last verified transfer.

## Operation
- **States:** IDLE, SHIFT, VERIFY, DONE (enum in package).
- **IDLE:**
  - On `start=1`, capture `cfg_data` into the internal shift image and latch `verify_en`.
  - Clear `err_cnt` and `verify_ok`, and go to SHIFT.
  - A `start` in any other state is ignored.
- **SHIFT / VERIFY:**
  - The bit index runs 0..TOTAL-1.
  - Each bit occupies 2*CLK_DIV cycles: `SCK_SC` is low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - `D_SC` changes only coincident with the `SCK_SC` high→low transition (or state entry), so it is stable across each rising edge.
- **End of SHIFT:** after bit TOTAL-1's high phase, go to VERIFY if the latched verify flag is set, else DONE. The index wraps to 0.
- **VERIFY:**
  - Resend the same image in the same order.
  - On the `CK_SC` edge where `SCK_SC` goes low→high for bit k, compare `Q_SC` with image bit k.
  - Each mismatch increments `err_cnt`. It cannot overflow because its width holds TOTAL.
- **DONE:**
  - Assert `done` for one cycle, set `verify_ok = verified && err_cnt==0`, and go to IDLE.
  - `err_cnt` and `verify_ok` hold until the next accepted start.
- **Outputs:** `busy` and `SC_EN` are high in SHIFT and VERIFY. `SC_EN` is low in DONE; `busy` is also high in DONE.
- **`rst` at any state, including mid-shift:** at the next edge go to IDLE and apply reset values. The shift image need not be cleared.

## Timing
- **Reset values:** `D_SC=0`, `SCK_SC=0`, `SC_EN=0`, `busy=0`, `done=0`, `err_cnt=0`, `verify_ok=0`.
- **Start latency:** if `start` is sampled at edge t, then after edge t: `busy=1`, `SC_EN=1`, `SCK_SC=0`, and `D_SC` = first bit.
- **Pass length:** exactly TOTAL*2*CLK_DIV cycles. `busy` lasts P+1 cycles without verify and 2P+1 with verify, where P is the pass length.
- **Between passes:** `SCK_SC` is low. There is no idle gap, so VERIFY bit 0's low phase follows immediately.
- **Back-to-back:** `start` held high re-triggers on the cycle after DONE, since IDLE lasts at least one cycle.
- **Verify sampling:** `Q_SC` is sampled in the same cycle `SCK_SC` rises, i.e. the value present before the chain reacts to that edge. The chain returns bit k of pass 1 during VERIFY bit k.

## Structure
- **Package `sc_pkg`:**
  - state enum
  - `SC_BITS_MAROC = 829` default constant
  - `sc_cnt_w(TOTAL)` helper
- **Sub-module `sc_clk_div`:** CLK_DIV phase counter producing `SCK_SC` plus one-cycle `rise`/`fall` strobes, with enable and sync reset. The loader FSM consumes the strobes.

## Test plan
1. SC_BITS=8, N_ASIC=2, CLK_DIV=2, LSB_FIRST=1, `cfg_data=16'hA5C3`, `verify_en=0`, one start → `D_SC` per bit reads 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1. `busy` is high 65 cycles, `done` pulses once, `verify_ok=0`.
2. Same setup with `verify_en=1` and a bench loopback (16-flop shift register clocked on `SCK_SC` rise, output to `Q_SC`) → `err_cnt=0`, `verify_ok=1`, `busy` 129 cycles.
3. As scenario 2, but the bench inverts `Q_SC` for VERIFY bit 5 → `err_cnt=1`, `verify_ok=0`.
4. LSB_FIRST=0 with `16'hA5C3` → first `D_SC` bit is 1 (bit 15), second is 0.
5. `rst` asserted at busy cycle 20, and `start` pulsed during busy in a separate run → reset values on the next edge for the former; the transfer is unaffected for the latter.
6. Defaults (829, 1, 1, 1), no verify → exactly 829 `SCK_SC` rising edges, `busy` 1659 cycles.

Source files
------------

// File: rtl/sc_pkg.sv
// Shared state encoding and sizing helpers for the slow-control chain loader.
package sc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_VERIFY,
    ST_DONE
  } sc_state_t;

  localparam int SC_BITS_MAROC = 829;

  // Width of a counter that must be able to hold the value `total` itself.
  function automatic int sc_cnt_w(input int total);
    return (total < 1) ? 1 : $clog2(total + 1);
  endfunction

endpackage

// File: rtl/sc_clk_div.sv
// Serial-clock generator: SCK is low for CLK_DIV cycles then high for CLK_DIV
// cycles; rise/fall flag the clock edge on which SCK is about to toggle.
module sc_clk_div #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] phase;
  logic          wrap;

  assign wrap = en && (phase == LAST);
  assign rise = wrap && !sck;
  assign fall = wrap && sck;

  // Disabling parks the divider at the start of a low phase, so every transfer begins aligned.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      phase <= '0;
      sck   <= 1'b0;
    end else if (wrap) begin
      phase <= '0;
      sck   <= ~sck;
    end else begin
      phase <= phase + PW'(1);
    end
  end

endmodule

// File: rtl/sc_chain_loader.sv
// Slow-control serializer: shifts a captured configuration image into an ASIC
// daisy chain and optionally re-shifts it while checking the returned stream.
module sc_chain_loader
  import sc_pkg::*;
#(
  parameter int SC_BITS   = SC_BITS_MAROC,
  parameter int N_ASIC    = 1,
  parameter int CLK_DIV   = 1,
  parameter int LSB_FIRST = 1,
  localparam int TOTAL    = SC_BITS * N_ASIC,
  localparam int CW       = sc_cnt_w(TOTAL)
) (
  input  logic             CK_SC,
  input  logic             rst,
  input  logic             start,
  input  logic             verify_en,
  input  logic [TOTAL-1:0] cfg_data,
  input  logic             Q_SC,
  output logic             D_SC,
  output logic             SCK_SC,
  output logic             SC_EN,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    err_cnt,
  output logic             verify_ok
);

  localparam logic [CW-1:0] LAST_BIT = CW'(TOTAL - 1);

  sc_state_t        state;
  logic [TOTAL-1:0] image;
  logic [CW-1:0]    bit_idx;
  logic             verify_req;
  logic             rise;
  logic             fall;

  sc_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk  (CK_SC),
    .rst  (rst),
    .en   (SC_EN),
    .sck  (SCK_SC),
    .rise (rise),
    .fall (fall)
  );

  function automatic logic first_bit(input logic [TOTAL-1:0] img);
    return (LSB_FIRST != 0) ? img[0] : img[TOTAL-1];
  endfunction

  // The image rotates rather than shifts, so after one pass it is back in place for verify.
  function automatic logic [TOTAL-1:0] rotate(input logic [TOTAL-1:0] img);
    return (LSB_FIRST != 0) ? {img[0], img[TOTAL-1:1]} : {img[TOTAL-2:0], img[TOTAL-1]};
  endfunction

  always_ff @(posedge CK_SC) begin
    if (rst) begin
      state      <= ST_IDLE;
      D_SC       <= 1'b0;
      SC_EN      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_cnt    <= '0;
      verify_ok  <= 1'b0;
      bit_idx    <= '0;
      verify_req <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            image      <= cfg_data;
            verify_req <= verify_en;
            err_cnt    <= '0;
            verify_ok  <= 1'b0;
            bit_idx    <= '0;
            D_SC       <= first_bit(cfg_data);
            SC_EN      <= 1'b1;
            busy       <= 1'b1;
            state      <= ST_SHIFT;
          end
        end
        ST_SHIFT, ST_VERIFY: begin
          // D_SC holds the expected bit for the whole bit period, so it is the compare reference.
          if (state == ST_VERIFY && rise && (Q_SC != D_SC)) begin
            err_cnt <= err_cnt + CW'(1);
          end
          if (fall) begin
            image <= rotate(image);
            D_SC  <= first_bit(rotate(image));
            if (bit_idx == LAST_BIT) begin
              bit_idx <= '0;
              if (state == ST_SHIFT && verify_req) begin
                state <= ST_VERIFY;
              end else begin
                state     <= ST_DONE;
                SC_EN     <= 1'b0;
                D_SC      <= 1'b0;
                done      <= 1'b1;
                verify_ok <= verify_req && (err_cnt == '0);
              end
            end else begin
              bit_idx <= bit_idx + CW'(1);
            end
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_chain_loader.sv
// Self-checking bench: three loader instances (small LSB-first with loopback,
// small MSB-first, full-size default) against a bit-list reference model.
module tb_sc_chain_loader;
  import sc_pkg::*;

  localparam int CWS = sc_cnt_w(16);
  localparam int CWD = sc_cnt_w(829);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Instance A: 8x2 bits, CLK_DIV=2, LSB first, with bench loopback chain
  logic           rst_a = 1'b1, start_a = 1'b0, ver_a = 1'b0;
  logic [15:0]    cfg_a = '0;
  logic           q_a, d_a, sck_a, en_a, busy_a, done_a, vok_a;
  logic [CWS-1:0] err_a;

  // Instance B: 8x2 bits, CLK_DIV=1, MSB first
  logic           rst_b = 1'b1, start_b = 1'b0;
  logic [15:0]    cfg_b = '0;
  logic           d_b, sck_b, en_b, busy_b, done_b, vok_b;
  logic [CWS-1:0] err_b;

  // Instance C: default parameters
  logic           rst_c = 1'b1, start_c = 1'b0;
  logic [828:0]   cfg_c = '0;
  logic           d_c, sck_c, en_c, busy_c, done_c, vok_c;
  logic [CWD-1:0] err_c;

  sc_chain_loader #(.SC_BITS(8), .N_ASIC(2), .CLK_DIV(2), .LSB_FIRST(1)) dut_a (
    .CK_SC(clk), .rst(rst_a), .start(start_a), .verify_en(ver_a), .cfg_data(cfg_a),
    .Q_SC(q_a), .D_SC(d_a), .SCK_SC(sck_a), .SC_EN(en_a), .busy(busy_a),
    .done(done_a), .err_cnt(err_a), .verify_ok(vok_a));

  sc_chain_loader #(.SC_BITS(8), .N_ASIC(2), .CLK_DIV(1), .LSB_FIRST(0)) dut_b (
    .CK_SC(clk), .rst(rst_b), .start(start_b), .verify_en(1'b0), .cfg_data(cfg_b),
    .Q_SC(1'b0), .D_SC(d_b), .SCK_SC(sck_b), .SC_EN(en_b), .busy(busy_b),
    .done(done_b), .err_cnt(err_b), .verify_ok(vok_b));

  sc_chain_loader dut_c (
    .CK_SC(clk), .rst(rst_c), .start(start_c), .verify_en(1'b0), .cfg_data(cfg_c),
    .Q_SC(1'b0), .D_SC(d_c), .SCK_SC(sck_c), .SC_EN(en_c), .busy(busy_c),
    .done(done_c), .err_cnt(err_c), .verify_ok(vok_c));

  // Loopback model of a 16-flop chain clocked on SCK rise; flip_at corrupts one returned bit.
  logic [15:0] lb = '0;
  int rise_cnt_a = 0;
  int flip_at = -1;
  always @(posedge sck_a) begin
    lb <= {lb[14:0], d_a};
    rise_cnt_a <= rise_cnt_a + 1;
  end
  assign q_a = lb[15] ^ (rise_cnt_a == flip_at);

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_a(input string tag);
    check_output({tag, "_d"}, 32'(d_a), 0);
    check_output({tag, "_sck"}, 32'(sck_a), 0);
    check_output({tag, "_en"}, 32'(en_a), 0);
    check_output({tag, "_busy"}, 32'(busy_a), 0);
    check_output({tag, "_done"}, 32'(done_a), 0);
    check_output({tag, "_err"}, 32'(err_a), 0);
    check_output({tag, "_vok"}, 32'(vok_a), 0);
  endtask

  // One transfer on instance A; rst_at/mid_at select an abort or a stray start at that busy cycle.
  task automatic apply_stimulus_a(input logic [15:0] cfg, input bit ver, input int flip_k,
                                  input int rst_at, input int mid_at);
    bit   exp_bits[$];
    logic got_bits[$];
    int   busy_cycles = 1;
    int   done_cnt = 0;
    int   exp_err = 0;
    int   budget = 0;
    int   passes;
    logic prev_sck = 1'b0;
    for (int k = 0; k < 16; k++) exp_bits.push_back(cfg[k]);
    if (ver) begin
      for (int k = 0; k < 16; k++) begin
        bit ret;
        ret = exp_bits[k] ^ (k == flip_k);
        if (ret != exp_bits[k]) exp_err++;
      end
    end
    passes = ver ? 2 : 1;
    @(negedge clk);
    cfg_a = cfg; ver_a = ver; start_a = 1'b1;
    flip_at = (ver && flip_k >= 0) ? rise_cnt_a + 16 + flip_k : -1;
    @(negedge clk);
    start_a = 1'b0;
    check_output("a_start_busy", 32'(busy_a), 1);
    check_output("a_start_en", 32'(en_a), 1);
    check_output("a_start_sck", 32'(sck_a), 0);
    check_output("a_start_d", 32'(d_a), 32'(exp_bits[0]));
    while (busy_a === 1'b1 && budget < 400) begin
      if (sck_a && !prev_sck) got_bits.push_back(d_a);
      prev_sck = sck_a;
      if (done_a === 1'b1) done_cnt++;
      if (busy_cycles == rst_at) begin
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        check_reset_a("a_midrst");
        flip_at = -1;
        return;
      end
      start_a = (busy_cycles == mid_at);
      @(negedge clk);
      budget++;
      if (busy_a === 1'b1) busy_cycles++;
    end
    start_a = 1'b0;
    check_output("a_timeout", 32'(budget < 400), 1);
    check_output("a_busy_len", 32'(busy_cycles), 32'(passes * 64 + 1));
    check_output("a_done_cnt", 32'(done_cnt), 1);
    check_output("a_err_cnt", 32'(err_a), 32'(exp_err));
    check_output("a_verify_ok", 32'(vok_a), 32'(ver && exp_err == 0));
    check_output("a_nbits", 32'(got_bits.size()), 32'(passes * 16));
    for (int k = 0; k < got_bits.size() && k < 32; k++)
      check_output($sformatf("a_bit%0d", k), 32'(got_bits[k]), 32'(exp_bits[k % 16]));
    flip_at = -1;
  endtask

  task automatic apply_stimulus_b(input logic [15:0] cfg);
    logic got_bits[$];
    int   busy_cycles = 1;
    int   done_cnt = 0;
    int   budget = 0;
    logic prev_sck = 1'b0;
    @(negedge clk);
    cfg_b = cfg; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    check_output("b_start_en", 32'(en_b), 1);
    check_output("b_first_d", 32'(d_b), 32'(cfg[15]));
    while (busy_b === 1'b1 && budget < 200) begin
      if (sck_b && !prev_sck) got_bits.push_back(d_b);
      prev_sck = sck_b;
      if (done_b === 1'b1) done_cnt++;
      @(negedge clk);
      budget++;
      if (busy_b === 1'b1) busy_cycles++;
    end
    check_output("b_timeout", 32'(budget < 200), 1);
    check_output("b_busy_len", 32'(busy_cycles), 33);
    check_output("b_done_cnt", 32'(done_cnt), 1);
    check_output("b_err_vok", {err_b, vok_b}, 0);
    check_output("b_nbits", 32'(got_bits.size()), 16);
    for (int k = 0; k < got_bits.size() && k < 16; k++)
      check_output($sformatf("b_bit%0d", k), 32'(got_bits[k]), 32'(cfg[15 - k]));
  endtask

  task automatic apply_stimulus_c();
    logic [828:0] got = '0;
    int   rises = 0;
    int   busy_cycles = 1;
    int   done_cnt = 0;
    int   budget = 0;
    logic prev_sck = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 829; i++) cfg_c[i] = 1'($urandom_range(0, 1));
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    while (busy_c === 1'b1 && budget < 4000) begin
      if (sck_c && !prev_sck) begin
        if (rises < 829) got[rises] = d_c;
        rises++;
      end
      prev_sck = sck_c;
      if (done_c === 1'b1) done_cnt++;
      @(negedge clk);
      budget++;
      if (busy_c === 1'b1) busy_cycles++;
    end
    check_output("c_timeout", 32'(budget < 4000), 1);
    check_output("c_rises", 32'(rises), 829);
    check_output("c_busy_len", 32'(busy_cycles), 1659);
    check_output("c_done_cnt", 32'(done_cnt), 1);
    check_output("c_err_vok", {err_c, vok_c}, 0);
    n_vec++;
    assert (got === cfg_c) else begin
      n_err++;
      $error("[TB] FAIL c_image: observed %0d differing bits expected 0", $countones(got ^ cfg_c));
    end
  endtask

  initial begin
    int flip;
    repeat (2) @(negedge clk);
    check_reset_a("a_por");
    check_output("b_por", {d_b, sck_b, en_b, busy_b, done_b, err_b, vok_b}, 0);
    check_output("c_por", {d_c, sck_c, en_c, busy_c, done_c, err_c, vok_c}, 0);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    @(negedge clk);

    $display("[TB] fixed image, no verify");
    apply_stimulus_a(16'hA5C3, 1'b0, -1, -1, -1);
    $display("[TB] fixed image, verify with clean loopback");
    apply_stimulus_a(16'hA5C3, 1'b1, -1, -1, -1);
    $display("[TB] fixed image, verify with bit 5 corrupted");
    apply_stimulus_a(16'hA5C3, 1'b1, 5, -1, -1);
    $display("[TB] reset mid-shift");
    apply_stimulus_a(16'($urandom), 1'b1, -1, 20, -1);
    repeat (2) @(negedge clk);
    check_output("a_idle_after_rst", 32'(busy_a), 0);
    $display("[TB] stray start while busy");
    apply_stimulus_a(16'($urandom), 1'b1, -1, -1, 10);

    for (int i = 0; i < 4; i++) begin
      flip = int'($urandom_range(0, 16));
      apply_stimulus_a(16'($urandom), 1'($urandom_range(0, 1)), (flip == 16) ? -1 : flip, -1, -1);
    end

    $display("[TB] MSB-first instance");
    apply_stimulus_b(16'hA5C3);
    for (int i = 0; i < 3; i++) apply_stimulus_b(16'($urandom));

    $display("[TB] default-size instance");
    apply_stimulus_c();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
